phase_accumulator: RTL
======================

Name: phase_accumulator

Overview:
- Consumer of the vibrato value: builds each operator's per-sample phase increment from fnum, block, mult and the LFO vibrato offset.
- Stores one phase accumulator per operator in an internal memory and updates it by read-modify-write.
- Outputs the top phase bits to the waveform/sine lookup stage.
- Time-multiplexed: the operator-slot sequencer presents at most one operator per cycle.

Parameters:
- NUM_OPERATORS, 18, number of accumulator slots (indices 0..NUM_OPERATORS-1).
- PHASE_ACC_WIDTH, 20, accumulator width; wraps modulo 2^PHASE_ACC_WIDTH.
- PHASE_OUT_WIDTH, 10, output phase width = acc[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH].
- REG_FNUM_WIDTH, 10, fnum width.
- REG_BLOCK_WIDTH, 3, block (octave) width.
- REG_MULT_WIDTH, 4, mult register width.
- VIB_VAL_WIDTH, 3, vibrato offset width; signed two's complement.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operator update request this cycle.
- op_num  in  5  operator index; values >= NUM_OPERATORS are ignored, with no write and no output.
- fnum  in  REG_FNUM_WIDTH  frequency number.
- block  in  REG_BLOCK_WIDTH  octave shift.
- mult  in  REG_MULT_WIDTH  frequency multiplier code.
- vib  in  1  vibrato enable for this operator.
- vib_val  in  VIB_VAL_WIDTH  signed vibrato offset from the LFO block.
- key_on_pulse  in  1  key-on rising edge for this operator; forces the accumulator to zero.
- busy  out  1  high during the post-reset clear sweep.
- phase_valid  out  1  phase_out valid strobe.
- phase_op  out  5  operator index for phase_out.
- phase_out  out  PHASE_OUT_WIDTH  updated phase.

Behaviour:
- Reset (synchronous, active-high): busy=1, phase_valid=0, phase_op=0, phase_out=0. The state machine enters CLEAR.
- State CLEAR:
  - A clear counter runs 0..NUM_OPERATORS-1, writing 0 to one slot per cycle.
  - op_valid is ignored.
  - After the last slot the block goes to RUN and busy drops. busy is high for exactly NUM_OPERATORS cycles after reset deasserts.
  - If reset reasserts during CLEAR or RUN, the counter restarts at 0 and in-flight pipeline entries are discarded.
- State RUN: three-stage pipeline, one request per cycle.
  - P0: inputs registered.
  - P1: accumulator read; increment computed.
  - P2: add, write back, outputs registered.
  - phase_valid asserts exactly 3 cycles after the accepted op_valid.
- Increment arithmetic:
  - fv = fnum + sign_extend(vib_val) when vib=1, otherwise fv = fnum. fv is clamped to 0..1023.
  - m2 is the mult code doubled: codes 0..15 map to 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
  - inc = ((fv << block) * m2) >> 2. Compute at full width (22 bits), then truncate to PHASE_ACC_WIDTH.
- Update:
  - new_acc = key_on_pulse ? 0 : (acc + inc) mod 2^PHASE_ACC_WIDTH.
  - The written value is new_acc. phase_out = new_acc top bits.
- Hazard: a P2 write to op N and a P1 read of op N in the same or adjacent cycle is resolved by OPL2_PHASE_FWD_EN (see below).
- Invalid op_num is dropped at P0: no write, phase_valid stays 0 for that slot.

Optional Feature:
- Macro: OPL2_PHASE_FWD_EN.
- Defined: P1 reads are forwarded from the P2 write (and from the memory write in flight) whenever op_num matches. Back-to-back requests to the same operator each see the previous result.
- Undefined: no forwarding, which saves logic. Same-operator requests must be at least 3 cycles apart; closer requests lose the earlier update, and the bench must flag this as a usage error, not an RTL error.

Test Plan:
- Reset, then idle: busy=1 for 18 cycles, then 0; phase_valid=0 throughout. Updating each op once with fnum=0 then gives phase_out=0 for all 18.
- op 0, fnum=0x200, block=4, mult=1, vib=0, issued 4 times 3 cycles apart: phase_out = 4, 8, 12, 16 (inc=4096).
- Wrap, op 1, fnum=1023, block=7, mult=15: inc=982080. Second update gives acc=915584, phase_out=894.
- Vibrato clamp:
  - fnum=1023, vib=1, vib_val=+3 behaves as fnum=1023.
  - fnum=2, vib=1, vib_val=-4 gives inc=0 and phase_out unchanged.
  - vib=0 ignores vib_val.
- key_on_pulse=1 on op 2 with nonzero acc: phase_out=0 that update. The next update with inc=4096 gives 4.
- OPL2_PHASE_FWD_EN defined: op 5 requested on 3 consecutive cycles with inc=4096 gives phase_out 4, 8, 12 on consecutive cycles. A mid-sweep reset restarts CLEAR and suppresses pending phase_valid.

Source files
------------

// File: rtl/phase_accumulator.sv
// Per-operator phase accumulator: builds the phase increment from fnum/block/mult/vibrato.
// Optional macro OPL2_PHASE_FWD_EN forwards in-flight updates to same-operator reads.
module phase_accumulator #(
    parameter int NUM_OPERATORS   = 18,
    parameter int PHASE_ACC_WIDTH = 20,
    parameter int PHASE_OUT_WIDTH = 10,
    parameter int REG_FNUM_WIDTH  = 10,
    parameter int REG_BLOCK_WIDTH = 3,
    parameter int REG_MULT_WIDTH  = 4,
    parameter int VIB_VAL_WIDTH   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       op_valid,
    input  logic [4:0]                 op_num,
    input  logic [REG_FNUM_WIDTH-1:0]  fnum,
    input  logic [REG_BLOCK_WIDTH-1:0] block,
    input  logic [REG_MULT_WIDTH-1:0]  mult,
    input  logic                       vib,
    input  logic [VIB_VAL_WIDTH-1:0]   vib_val,
    input  logic                       key_on_pulse,
    output logic                       busy,
    output logic                       phase_valid,
    output logic [4:0]                 phase_op,
    output logic [PHASE_OUT_WIDTH-1:0] phase_out
);

    localparam int SUM_W  = REG_FNUM_WIDTH + 2;
    localparam int PROD_W = REG_FNUM_WIDTH + (2 ** REG_BLOCK_WIDTH) - 1 + 5;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t state_q, state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;

    logic                       p0_valid_q, p0_valid_d;
    logic [4:0]                 p0_op_q, p0_op_d;
    logic [REG_FNUM_WIDTH-1:0]  p0_fnum_q, p0_fnum_d;
    logic [REG_BLOCK_WIDTH-1:0] p0_block_q, p0_block_d;
    logic [REG_MULT_WIDTH-1:0]  p0_mult_q, p0_mult_d;
    logic                       p0_vib_q, p0_vib_d;
    logic [VIB_VAL_WIDTH-1:0]   p0_vib_val_q, p0_vib_val_d;
    logic                       p0_kon_q, p0_kon_d;

    logic                       p1_valid_q, p1_valid_d;
    logic [4:0]                 p1_op_q, p1_op_d;
    logic [PHASE_ACC_WIDTH-1:0] p1_acc_q, p1_acc_d;
    logic [PHASE_ACC_WIDTH-1:0] p1_inc_q, p1_inc_d;
    logic                       p1_kon_q, p1_kon_d;

    logic                       phase_valid_q, phase_valid_d;
    logic [4:0]                 phase_op_q, phase_op_d;
    logic [PHASE_OUT_WIDTH-1:0] phase_out_q, phase_out_d;

    logic [PHASE_ACC_WIDTH-1:0] mem_q [NUM_OPERATORS];
    logic                       wr_en_d;
    logic [4:0]                 wr_addr_d;
    logic [PHASE_ACC_WIDTH-1:0] wr_data_d;

    logic signed [SUM_W-1:0]    fv_sum;
    logic [REG_FNUM_WIDTH-1:0]  fv;
    logic [4:0]                 m2;
    logic [PROD_W-1:0]          prod;
    logic [PHASE_ACC_WIDTH-1:0] new_acc;

    // Doubled multiplier: half-step code 0 and the repeated top codes
    function automatic logic [4:0] mult_x2(input logic [REG_MULT_WIDTH-1:0] m);
        case (m)
            4'd0:    mult_x2 = 5'd1;
            4'd1:    mult_x2 = 5'd2;
            4'd2:    mult_x2 = 5'd4;
            4'd3:    mult_x2 = 5'd6;
            4'd4:    mult_x2 = 5'd8;
            4'd5:    mult_x2 = 5'd10;
            4'd6:    mult_x2 = 5'd12;
            4'd7:    mult_x2 = 5'd14;
            4'd8:    mult_x2 = 5'd16;
            4'd9:    mult_x2 = 5'd18;
            4'd10:   mult_x2 = 5'd20;
            4'd11:   mult_x2 = 5'd20;
            4'd12:   mult_x2 = 5'd24;
            4'd13:   mult_x2 = 5'd24;
            default: mult_x2 = 5'd30;
        endcase
    endfunction

    // Clear sweep sequencing, then free-running RUN
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == 5'(NUM_OPERATORS - 1)) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 5'd1;
            end
        end
    end

    // P0: accept and register a request for a legal operator
    always_comb begin
        p0_valid_d   = op_valid && (state_q == ST_RUN)
                       && (op_num < 5'(NUM_OPERATORS));
        p0_op_d      = p0_valid_d ? op_num : p0_op_q;
        p0_fnum_d    = fnum;
        p0_block_d   = block;
        p0_mult_d    = mult;
        p0_vib_d     = vib;
        p0_vib_val_d = vib_val;
        p0_kon_d     = key_on_pulse;
    end

    // P2 arithmetic: next accumulator value of the operator in P1
    always_comb begin
        new_acc = p1_kon_q ? '0 : p1_acc_q + p1_inc_q;
    end

    // P1: accumulator read (optionally forwarded) and increment
    always_comb begin
        fv_sum = $signed({2'b00, p0_fnum_q});
        if (p0_vib_q) begin
            fv_sum = fv_sum + SUM_W'($signed(p0_vib_val_q));
        end
        if (fv_sum[SUM_W-1]) begin
            fv = '0;
        end else if (fv_sum[SUM_W-2]) begin
            fv = '1;
        end else begin
            fv = fv_sum[REG_FNUM_WIDTH-1:0];
        end
        m2       = mult_x2(p0_mult_q);
        prod     = (PROD_W'(fv) << p0_block_q) * PROD_W'(m2);
        p1_inc_d = PHASE_ACC_WIDTH'(prod >> 2);
        p1_acc_d = mem_q[p0_op_q];
`ifdef OPL2_PHASE_FWD_EN
        if (p1_valid_q && (p1_op_q == p0_op_q)) begin
            p1_acc_d = new_acc;
        end
`endif
        p1_valid_d = p0_valid_q;
        p1_op_d    = p0_op_q;
        p1_kon_d   = p0_kon_q;
    end

    // P2: write-back selection and output registers
    always_comb begin
        phase_valid_d = p1_valid_q;
        phase_op_d    = p1_valid_q ? p1_op_q : phase_op_q;
        phase_out_d   = p1_valid_q
                        ? new_acc[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH]
                        : phase_out_q;
        if (state_q == ST_CLEAR) begin
            wr_en_d   = !reset;
            wr_addr_d = clr_cnt_q;
            wr_data_d = '0;
        end else begin
            wr_en_d   = p1_valid_q && !reset;
            wr_addr_d = p1_op_q;
            wr_data_d = new_acc;
        end
    end

    // Control and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            p0_valid_q    <= 1'b0;
            p1_valid_q    <= 1'b0;
            phase_valid_q <= 1'b0;
            phase_op_q    <= '0;
            phase_out_q   <= '0;
            p0_op_q       <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            p0_valid_q    <= p0_valid_d;
            p1_valid_q    <= p1_valid_d;
            phase_valid_q <= phase_valid_d;
            phase_op_q    <= phase_op_d;
            phase_out_q   <= phase_out_d;
            p0_op_q       <= p0_op_d;
        end
    end

    // Datapath registers; validity is carried by the control flops
    always_ff @(posedge clk) begin
        p0_fnum_q    <= p0_fnum_d;
        p0_block_q   <= p0_block_d;
        p0_mult_q    <= p0_mult_d;
        p0_vib_q     <= p0_vib_d;
        p0_vib_val_q <= p0_vib_val_d;
        p0_kon_q     <= p0_kon_d;
        p1_op_q      <= p1_op_d;
        p1_acc_q     <= p1_acc_d;
        p1_inc_q     <= p1_inc_d;
        p1_kon_q     <= p1_kon_d;
    end

    // Accumulator memory: clear sweep or P2 write-back
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign busy        = (state_q == ST_CLEAR);
    assign phase_valid = phase_valid_q;
    assign phase_op    = phase_op_q;
    assign phase_out   = phase_out_q;

endmodule
